cron_digit: RTL

CRON_DIGIT -- requirements
Module: cron_digit

---
 rtl/cron_digit.sv | 88 ++++++++
 1 files changed

// File: rtl/cron_digit.sv
// One decimal/modulo digit of a cascadable up/down counter with a synchronous
// carry chain and a built-in seven-segment decoder.
module cron_digit #(
  parameter int MOD            = 6,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       P,
  input  logic       EN,
  input  logic       CI,
  input  logic       DIR,
  input  logic       LD,
  input  logic [3:0] D,
  output logic [3:0] Q,
  output logic       CO,
  output logic       ADS,
  output logic       BDS,
  output logic       CDS,
  output logic       DDS,
  output logic       EDS,
  output logic       FDS,
  output logic       GDS
);

  localparam logic [3:0] QMAX = 4'(MOD - 1);

  function automatic logic [3:0] clamp_load(input logic [3:0] v);
    return (v > QMAX) ? QMAX : v;
  endfunction

  // Segment pattern ordered {a,b,c,d,e,f,g}; codes above 9 blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  logic [3:0] q_nxt;
  logic       terminal;
  logic [6:0] seg_drv;

  // Out-of-range codes fall into the wrap branches so the digit self-recovers.
  always_comb begin
    q_nxt = Q;
    if (P) begin
      q_nxt = 4'd0;
    end else if (LD) begin
      q_nxt = clamp_load(D);
    end else if (EN && CI) begin
      if (!DIR) begin
        q_nxt = (Q >= QMAX) ? 4'd0 : Q + 4'd1;
      end else begin
        q_nxt = ((Q == 4'd0) || (Q > QMAX)) ? QMAX : Q - 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Q <= 4'd0;
    end else begin
      Q <= q_nxt;
    end
  end

  // Carry is suppressed whenever this edge will not perform a count step.
  always_comb begin
    terminal = DIR ? (Q == 4'd0) : (Q == QMAX);
    CO       = EN & CI & terminal & ~P & ~LD & ~RST;
    seg_drv  = SEG_ACTIVE_LOW ? ~seg_decode(Q) : seg_decode(Q);
  end

  assign {ADS, BDS, CDS, DDS, EDS, FDS, GDS} = seg_drv;

endmodule
